// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and defaults: queue entry layout and counter sizing.
package fetch_pkg;

    localparam int          DEPTH_DEF    = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Occupancy and in-flight counters must be able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_w(DEPTH_DEF);

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect, decode-side output and halt flag.
interface fetch_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        halted;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, halted,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr, halted,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, instr} entries with flush and occupancy output.
// Latency: a push is visible at the head the following cycle; head is read combinationally.
// Backpressure: push when full is ignored unless a pop happens in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  entry_t                 push_dat,
    input  logic                   pop,
    output entry_t                 head_dat,
    output logic                   head_vld,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

    // Storage is not reset, so an empty queue presents zeros rather than stale words.
    assign head_vld  = (count != '0);
    assign head_dat  = head_vld ? mem[rd_ptr] : '0;
    assign occupancy = count;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: sequential imem requests, response queueing with PC, redirect flush/drop; FETCH_HALT_EN adds halt on zero word.
// Latency: request accept to out_valid is memory latency + 1 cycle; first request one cycle after reset release.
// Backpressure: requests issue only while queue occupancy + outstanding < DEPTH, so out_ready low throttles imem.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEPTH_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input logic     clk,
    input logic     reset,
    fetch_if.master bus
);
    localparam int             CNT_W   = cnt_w(DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] occupancy;
    logic             run_q;
    logic             credit_ok;
    logic             halt_stop;
    logic             req_vld;
    logic             req_fire;
    logic             rsp_live;
    logic             drop_hit;
    logic             push_vld;
    logic             pop_vld;
    logic             head_vld;
    entry_t           head_dat;
    entry_t           rsp_dat;

    assign credit_ok = ({1'b0, occupancy} + {1'b0, outstanding}) < DEPTH_C;
    assign req_vld   = run_q && credit_ok && !halt_stop;
    assign req_fire  = req_vld && bus.imem_req_ready;

    // A response with nothing in flight is a leftover from before reset and is ignored.
    assign rsp_live  = bus.imem_rsp_valid && (outstanding != '0);
    assign drop_hit  = rsp_live && (drop_cnt != '0);
    assign push_vld  = rsp_live && !drop_hit && !bus.redirect_valid && !halt_stop;
    assign pop_vld   = head_vld && bus.out_ready;

    assign outstanding_nxt = outstanding + {{(CNT_W-1){1'b0}}, req_fire}
                                         - {{(CNT_W-1){1'b0}}, rsp_live};

    assign rsp_dat.pc    = rsp_pc;
    assign rsp_dat.instr = bus.imem_rsp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q       <= 1'b0;
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            run_q       <= 1'b1;
            outstanding <= outstanding_nxt;
            // Everything still in flight after this cycle belongs to the old path.
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
                rsp_pc   <= bus.redirect_pc;
                drop_cnt <= outstanding_nxt;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 32'd4;
                if (push_vld) rsp_pc   <= rsp_pc + 32'd4;
                if (drop_hit) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halt_stop <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            if (push_vld && (bus.imem_rsp_data == 32'h0)) halt_stop <= 1'b1;
            if (pop_vld && (head_dat.instr == 32'h0))     halted_q  <= 1'b1;
        end
    end

    assign bus.halted = halted_q;
`else
    assign halt_stop  = 1'b0;
    assign bus.halted = 1'b0;
`endif

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (push_vld),
        .push_dat  (rsp_dat),
        .pop       (pop_vld),
        .head_dat  (head_dat),
        .head_vld  (head_vld),
        .occupancy (occupancy)
    );

    assign bus.imem_req_valid = req_vld;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.out_valid      = head_vld;
    assign bus.out_pc         = head_dat.pc;
    assign bus.out_instr      = head_dat.instr;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter DEPTH, 4, prefetch queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_addr  output  32  byte address of the request.
REQ-007 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-008 imem_rsp_valid  input  1  response data valid; responses return in request order, latency >= 1 cycle.
REQ-009 imem_rsp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect from the execute stage.
REQ-011 redirect_pc  input  32  new fetch address.
REQ-012 out_valid  output  1  head of queue holds an instruction.
REQ-013 out_pc  output  32  PC of the head instruction.
REQ-014 out_instr  output  32  head instruction word.
REQ-015 out_ready  input  1  decode consumes the head this cycle.
REQ-016 halted  output  1  fetch has stopped on a halt word.

Function
REQ-017 Request accepted when imem_req_valid && imem_req_ready; fetch_pc then advances by 4, wrapping modulo 2^32.
REQ-018 imem_req_valid asserts only while occupancy + outstanding < DEPTH, never overflowing the queue.
REQ-019 imem_req_addr equals fetch_pc and holds stable while valid and not ready.
REQ-020 Each valid response not marked for drop is pushed as {pc, instr} with the pc of its request; out_valid asserts the cycle after the push.
REQ-021 Pop on out_valid && out_ready; simultaneous push and pop keep occupancy unchanged, including when full.
REQ-022 out_pc and out_instr stay stable while out_valid && !out_ready, except under redirect.
REQ-023 On redirect_valid, the queue is flushed next cycle, fetch_pc becomes redirect_pc, and all in-flight requests, including one accepted the same cycle, are counted for drop.
REQ-024 Dropped responses are discarded without a push; new requests may issue while drops are pending.
REQ-025 A redirect coinciding with a pop completes the pop first; a redirect coinciding with a push discards the push.
REQ-026 Back-to-back redirects: the last one wins, and drop counts accumulate.

Reset
REQ-027 During reset: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0, halted=0, queue empty, outstanding=0, drop count=0.
REQ-028 imem_req_valid may first assert in the first cycle after reset deasserts; reset asserted mid-operation abandons all in-flight responses.

Configuration
REQ-029 Macro FETCH_HALT_EN: when defined, pushing instr 32'h0000_0000 stops all further requests and drops later responses; halted sets after that entry pops; only reset clears it; redirect does not.
REQ-030 Without FETCH_HALT_EN, the zero word is an ordinary instruction and halted is tied 0.

Structure
REQ-031 Package fetch_pkg holds the DEPTH default, the RESET_PC default, the entry typedef {pc[31:0], instr[31:0]}, and the counter width $clog2(DEPTH)+1.
REQ-032 Sub-module fetch_fifo: synchronous FIFO with flush, push/pop, and occupancy outputs; fetch_stage contains the PC, credit, and drop logic.

Verification
REQ-033 Test 1, reset release, 1-cycle memory, out_ready=1: addresses 0,4,8,... are issued, and out_pc/out_instr match memory[0],[1],... with throughput 1/cycle after fill.
REQ-034 Test 2, out_ready=0 for 20 cycles: exactly DEPTH (4) requests are issued, then imem_req_valid=0, and the head holds PC 0 stable.
REQ-035 Test 3, 3-cycle memory latency with redirect to 0x100 while 2 requests are outstanding: both stale responses are dropped, and the next out_pc=0x100.
REQ-036 Test 4, redirect and pop in the same cycle at full queue: the popped entry is delivered once, the queue is empty next cycle, and fetch resumes at redirect_pc.
REQ-037 Test 5, FETCH_HALT_EN with memory[3]=0: requests stop, the entries for PC 0..0xC are delivered, halted=1 after the pop of 0xC, and it stays 1 through a redirect.
REQ-038 Test 6, async reset asserted mid-stream with 2 outstanding: outputs clear immediately, and after release fetch restarts at RESET_PC with no stale pushes.
